mult_control: RTL and testbench



---
 rtl/mult_pkg.sv | 18 +
 rtl/mult_control.sv | 148 ++++++++++++++
 tb/tb_mult_control.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add signed multiplier sequencer.
// Holds the controller state encoding and the default operand width.
package mult_pkg;

    // Default operand width. This is also the number of add/shift iterations.
    localparam int MULT_N = 8;

    // Sequencer states.
    // ADD and SHIFT alternate once per operand bit.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } mult_state_t;

endpackage

// File: rtl/mult_control.sv
// Sequencing FSM for the 8-bit shift-add signed multiplier datapath.
// A run clears A/X, then alternates ADD (conditional on M = B[0]) and SHIFT
// N times. The last ADD subtracts to correct for the multiplier sign bit.
// The result is held in DONE until Run drops.
// Datapath register units stay outside this block; only strobes leave here.
module mult_control
    import mult_pkg::*;
#(
    parameter int N     = MULT_N,
    parameter int CNT_W = $clog2(N)
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Ld_B,
    output logic Clr_AX,
    output logic Ld_AX,
    output logic Fn,
    output logic Shift_En,
    output logic Busy,
    output logic Done
);

    // Index of the final iteration, which uses the subtracting adder.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    mult_state_t     state_r;
    mult_state_t     state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             last_iter_s;

    // The iteration counter is checked before it is incremented, so it never
    // wraps past N-1.
    assign last_iter_s = (cnt_r == LAST_CNT);

    // State and iteration counter registers, with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and counter decode.
    // Run and ClearA_LoadB only matter in IDLE and DONE.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (Run) begin
                    state_nxt_s = CLEAR;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CLEAR: begin
                cnt_nxt_s   = CNT_ZERO;
                state_nxt_s = ADD;
            end
            ADD: begin
                // The cycle is spent even when M=0, so latency does not
                // depend on the operand.
                state_nxt_s = SHIFT;
            end
            SHIFT: begin
                if (last_iter_s) begin
                    state_nxt_s = DONE;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                    state_nxt_s = ADD;
                end
            end
            DONE: begin
                // A new run needs Run released for at least one cycle.
                if (Run) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Moore output decode.
    // The Ld_B/Clr_AX pass-through in IDLE is the only input-dependent term
    // besides Ld_AX=M. Reset forces every strobe low, so an aborted run
    // leaves the datapath untouched.
    always_comb begin
        Ld_B     = 1'b0;
        Clr_AX   = 1'b0;
        Ld_AX    = 1'b0;
        Fn       = 1'b0;
        Shift_En = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        if (!Reset_n) begin
            Ld_B     = 1'b0;
            Clr_AX   = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // Run has priority: no load in the cycle that starts a run.
                    if (Run) begin
                        Ld_B   = 1'b0;
                        Clr_AX = 1'b0;
                    end else begin
                        Ld_B   = ClearA_LoadB;
                        Clr_AX = ClearA_LoadB;
                    end
                end
                CLEAR: begin
                    Clr_AX = 1'b1;
                    Busy   = 1'b1;
                end
                ADD: begin
                    Busy  = 1'b1;
                    Ld_AX = M;
                    // Fn is gated by M so that Fn is never high without Ld_AX.
                    Fn    = M & last_iter_s;
                end
                SHIFT: begin
                    Shift_En = 1'b1;
                    Busy     = 1'b1;
                end
                DONE: begin
                    Done = 1'b1;
                end
                default: begin
                    Busy = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_control.sv
// Directed bench for mult_control.
// Expected strobe patterns are hand-derived per cycle from the state
// sequence CLEAR, (ADDi, SHIFTi) x 8, DONE.
module tb_mult_control;

    logic Clk = 1'b0;
    logic Reset_n;
    logic Run;
    logic ClearA_LoadB;
    logic M;
    logic Ld_B, Clr_AX, Ld_AX, Fn, Shift_En, Busy, Done;

    // Output bit order: {Ld_B, Clr_AX, Ld_AX, Fn, Shift_En, Busy, Done}
    logic [6:0] outs;
    assign outs = {Ld_B, Clr_AX, Ld_AX, Fn, Shift_En, Busy, Done};

    localparam logic [6:0] O_IDLE  = 7'b000_0000;
    localparam logic [6:0] O_LOAD  = 7'b110_0000;
    localparam logic [6:0] O_CLEAR = 7'b010_0010;
    localparam logic [6:0] O_SHIFT = 7'b000_0110;
    localparam logic [6:0] O_DONE  = 7'b000_0001;

    int n_cmp = 0;
    int n_mis = 0;

    mult_control dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .M            (M),
        .Ld_B         (Ld_B),
        .Clr_AX       (Clr_AX),
        .Ld_AX        (Ld_AX),
        .Fn           (Fn),
        .Shift_En     (Shift_En),
        .Busy         (Busy),
        .Done         (Done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // One multiply from IDLE.
    // M follows a model of B[0]. If abort_c >= 0, reset is asserted in that
    // cycle. ClearA_LoadB is held high and Run toggles mid-run to show that
    // both are ignored.
    task automatic do_run(input string nm, input logic [7:0] b, input int abort_c);
        logic [7:0] bm;
        logic [6:0] exp;
        logic       m;
        int         n_ld;
        int         n_sh;
        int         n_fn;
        int         it;
        bit         aborted;
        bm = b;
        n_ld = 0;
        n_sh = 0;
        n_fn = 0;
        aborted = 1'b0;
        Run = 1'b1;
        ClearA_LoadB = 1'b1;
        #2;
        chk({nm, "_idle_runprio"}, {25'd0, outs}, {25'd0, O_IDLE});
        step();
        for (int c = 0; c < 17 && !aborted; c++) begin
            m = bm[0];
            M = m;
            Run = (c >= 2 && c <= 14) ? ((c % 2) == 0) : 1'b1;
            if (c == abort_c) begin
                Reset_n = 1'b0;
                #2;
                chk($sformatf("%s_abort_c%0d", nm, c), {25'd0, outs}, {25'd0, O_IDLE});
                step();
                Reset_n = 1'b1;
                Run = 1'b0;
                ClearA_LoadB = 1'b1;
                #2;
                chk({nm, "_abort_then_idle"}, {25'd0, outs}, {25'd0, O_LOAD});
                ClearA_LoadB = 1'b0;
                step();
                aborted = 1'b1;
            end else begin
                if (c == 0) begin
                    exp = O_CLEAR;
                end else if ((c % 2) == 1) begin
                    it  = (c - 1) / 2;
                    exp = {2'b00, m, m & (it == 7), 1'b0, 1'b1, 1'b0};
                end else begin
                    exp = O_SHIFT;
                end
                #2;
                chk($sformatf("%s_c%0d", nm, c), {25'd0, outs}, {25'd0, exp});
                if (Ld_AX) n_ld++;
                if (Fn) n_fn++;
                if (Shift_En) n_sh++;
                if (c > 0 && (c % 2) == 0) bm = bm >> 1;
                step();
            end
        end
        if (!aborted) begin
            Run = 1'b1;
            #2;
            chk({nm, "_done_e17"}, {25'd0, outs}, {25'd0, O_DONE});
            chk({nm, "_n_shift"}, 32'(n_sh), 32'd8);
            chk({nm, "_n_ldax"}, 32'(n_ld), 32'($countones(b)));
            chk({nm, "_n_fn"}, 32'(n_fn), {31'd0, b[7]});
            ClearA_LoadB = 1'b0;
        end
    endtask

    // Drop Run in DONE: DONE holds this cycle, then the FSM returns to IDLE.
    task automatic release_run(input string nm);
        Run = 1'b0;
        ClearA_LoadB = 1'b0;
        #2;
        chk({nm, "_rel_done"}, {25'd0, outs}, {25'd0, O_DONE});
        step();
        chk({nm, "_rel_idle"}, {25'd0, outs}, {25'd0, O_IDLE});
    endtask

    initial begin
        Reset_n = 1'b0;
        Run = 1'b1;
        ClearA_LoadB = 1'b1;
        M = 1'b0;
        #2;
        chk("rst_t0", {25'd0, outs}, {25'd0, O_IDLE});
        step();
        chk("rst_c1", {25'd0, outs}, {25'd0, O_IDLE});
        step();
        chk("rst_c2", {25'd0, outs}, {25'd0, O_IDLE});

        // Release reset: IDLE, Ld_B/Clr_AX follow ClearA_LoadB
        Reset_n = 1'b1;
        Run = 1'b0;
        ClearA_LoadB = 1'b1;
        #2;
        chk("rel_load", {25'd0, outs}, {25'd0, O_LOAD});
        ClearA_LoadB = 1'b0;
        #1;
        chk("rel_noload", {25'd0, outs}, {25'd0, O_IDLE});
        step();

        // Load for exactly three cycles
        for (int i = 0; i < 3; i++) begin
            ClearA_LoadB = 1'b1;
            #2;
            chk($sformatf("load_%0d", i), {25'd0, outs}, {25'd0, O_LOAD});
            step();
        end
        ClearA_LoadB = 1'b0;
        #2;
        chk("load_end", {25'd0, outs}, {25'd0, O_IDLE});
        step();
        chk("load_after", {25'd0, outs}, {25'd0, O_IDLE});

        // Full run B=1000_0001, then DONE hold with ClearA_LoadB pulsed
        do_run("b81", 8'b1000_0001, -1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("b81_hold_%0d", i), {25'd0, outs}, {25'd0, O_DONE});
        end
        ClearA_LoadB = 1'b1;
        #2;
        chk("done_cl_ignored", {25'd0, outs}, {25'd0, O_DONE});
        step();
        chk("done_cl_norun", {25'd0, outs}, {25'd0, O_DONE});
        ClearA_LoadB = 1'b0;
        release_run("b81");

        // Run low one cycle, then a new run restarts at CLEAR
        do_run("m0", 8'h00, -1);
        release_run("m0");
        do_run("m1", 8'hFF, -1);
        release_run("m1");

        // Reset during SHIFT3 (cycle index 8), then a full-latency restart
        do_run("abt", 8'hA5, 8);
        do_run("rst_again", 8'hA5, -1);
        release_run("rst_again");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
